// File: rtl/problema1_pio_pkg.sv
// Shared register map and pulse-timer state encoding for the output PIO.
// Latency: n/a (declarations only); backpressure: n/a.
package problema1_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN  = 3'd1;
    localparam logic [2:0] ADDR_PULSE_TRIG = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR     = 3'd5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PULSING = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/problema1_pulse_timer.sv
// One-shot pulse timer: holds an inversion mask for exactly len cycles after a trigger.
// Latency: mask/busy update at the trigger edge; next-state copies are exported combinationally. Backpressure: none.
module problema1_pulse_timer
    import problema1_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PULSE_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trig,
    input  logic [WIDTH-1:0]       trig_mask,
    input  logic [PULSE_CNT_W-1:0] len,
    output logic                   busy,
    output logic [WIDTH-1:0]       mask,
    output logic                   busy_nxt,
    output logic [WIDTH-1:0]       mask_nxt
);

    pulse_state_t           state_q, state_d;
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]       mask_q, mask_d;
    logic                   trig_go;
    logic                   trig_abort;

    assign trig_go    = trig && (trig_mask != '0) && (len != '0);
    assign trig_abort = trig && (trig_mask == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_go) begin
                    state_d = ST_PULSING;
                    cnt_d   = len;
                    mask_d  = trig_mask;
                end
            end
            ST_PULSING: begin
                // A fresh trigger beats both the abort path and the expiry on the same edge
                if (trig_go) begin
                    cnt_d  = len;
                    mask_d = trig_mask;
                end else if (trig_abort || (cnt_q == PULSE_CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    mask_d  = '0;
                end else begin
                    cnt_d = cnt_q - PULSE_CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    assign busy     = (state_q == ST_PULSING);
    assign mask     = mask_q;
    assign busy_nxt = (state_d == ST_PULSING);
    assign mask_nxt = mask_d;

endmodule

// File: rtl/problema1_pio_out.sv
// Avalon-MM output PIO with atomic set/clear and a one-shot inversion pulse on out_port.
// Latency: writes reach out_port at the sampling edge, reads return 1 cycle later; backpressure: none (no wait states).
module problema1_pio_out
    import problema1_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PULSE_CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]       data_q, data_d;
    logic [PULSE_CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0]       wd_w;
    logic                   wr;
    logic                   trig;
    logic                   busy;
    logic                   busy_nxt;
    logic [WIDTH-1:0]       mask;
    logic [WIDTH-1:0]       mask_nxt;
    logic [31:0]            rd_d;
    logic                   unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd_w      = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        trig   = 1'b0;
        if (wr) begin
            case (address)
                ADDR_DATA:       data_d = wd_w;
                ADDR_PULSE_LEN:  len_d  = writedata[PULSE_CNT_W-1:0];
                ADDR_PULSE_TRIG: trig   = 1'b1;
                ADDR_OUTSET:     data_d = data_q | wd_w;
                ADDR_OUTCLR:     data_d = data_q & ~wd_w;
                default:         ;
            endcase
        end
    end

    problema1_pulse_timer #(
        .WIDTH       (WIDTH),
        .PULSE_CNT_W (PULSE_CNT_W)
    ) u_pulse_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig      (trig),
        .trig_mask (wd_w),
        .len       (len_q),
        .busy      (busy),
        .mask      (mask),
        .busy_nxt  (busy_nxt),
        .mask_nxt  (mask_nxt)
    );

    // Read mux looks at pre-edge state, so a read racing a state change sees the old value
    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA:       rd_d = 32'(data_q);
            ADDR_PULSE_LEN:  rd_d = 32'(len_q);
            ADDR_PULSE_TRIG: rd_d = 32'(mask);
            ADDR_STATUS:     rd_d = {31'd0, busy};
            default:         rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            len_q    <= '0;
            readdata <= '0;
            out_port <= RESET_VALUE;
        end else begin
            data_q   <= data_d;
            len_q    <= len_d;
            readdata <= rd_d;
            out_port <= data_d ^ (busy_nxt ? mask_nxt : '0);
        end
    end

endmodule
